jtopl_timer_bank: RTL and testbench
===================================

JTOPL_TIMER_BANK -- requirements
Module: jtopl_timer_bank

Interface
REQ-001 The block SHALL have parameter NTIM, default 2, giving the number of timers (1..4).
REQ-002 The block SHALL have parameter CW, default 8, giving the counter and reload-value width (4..16).
REQ-003 The block SHALL have parameter PRE, default 72, giving the number of cen pulses per timer-0 tick (>=2).
REQ-004 The block SHALL have port clk, input, 1 bit: clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port cen, input, 1 bit: clock enable; all counting advances only on clk edges with cen=1.
REQ-007 The block SHALL have port cfg_we, input, 1 bit; cfg_sel, input, 2 bits; cfg_value, input, CW bits: reload-value write for timer cfg_sel.
REQ-008 The block SHALL have port ctl_we, input, 1 bit; ctl_start, ctl_mask and ctl_oneshot, inputs, NTIM bits each: control register write.
REQ-009 The block SHALL have port clr_flags, input, 1 bit: single-cycle pulse that clears all flags.
REQ-010 The block SHALL have port flags, output, NTIM bits; ovf, output, NTIM bits (one-clk overflow pulses); irq_n, output, 1 bit.
REQ-011 The block SHALL have ports rd_sel, input, 2 bits, and rd_count, output, CW bits: present only under JTOPL_TIMER_RDBACK_EN.

Function
REQ-012 Tick chain: a prescaler SHALL count cen pulses 0..PRE-1 and emit tick0 on the wrap; tick(i) for i>0 SHALL fire on every 4th tick(i-1); the chain free-runs regardless of timer state.
REQ-013 cfg_we SHALL latch cfg_value into value[cfg_sel] on the same edge; writes with cfg_sel>=NTIM SHALL be ignored; a new value SHALL affect the counter only at its next load.
REQ-014 ctl_we SHALL latch start, mask and oneshot registers; a 0->1 transition of start[i] SHALL load cnt[i]<=value[i] on that edge, independent of cen.
REQ-015 Rewriting start[i]=1 while already 1 SHALL NOT reload cnt[i]; start[i]=0 SHALL freeze cnt[i] at its current value.
REQ-016 Per timer, the states are IDLE (start=0) and RUN (start=1); in RUN, on each cen edge with tick(i), cnt[i] SHALL increment by 1.
REQ-017 Overflow: on a counting edge with cnt[i] equal to all ones, cnt[i] SHALL load value[i], ovf[i] SHALL pulse high for exactly one clk, and flags[i] SHALL set unless mask[i]=1.
REQ-018 value[i] equal to all ones SHALL overflow on every tick(i).
REQ-019 When oneshot[i]=1, overflow SHALL clear start[i] on the same edge (RUN->IDLE), with cnt[i] holding value[i].
REQ-020 ctl_we setting mask[i]=1 SHALL clear flags[i] on that edge.
REQ-021 clr_flags SHALL clear all flags; when it coincides with an overflow setting flags[i], set SHALL win for that bit.
REQ-022 ctl_we coinciding with an overflow in oneshot mode: the written start value SHALL win.
REQ-023 irq_n SHALL be registered: irq_n = NOT OR(flags), updating one clk after a flag changes.

Reset
REQ-024 rst_n low SHALL asynchronously clear prescaler, cnt, value, start, mask, oneshot, flags and ovf to 0, and drive irq_n to 1.
REQ-025 Reset asserted mid-count SHALL abandon the count; after release, no timer runs until a start 0->1 write.

Configuration
REQ-026 With JTOPL_TIMER_RDBACK_EN defined, rd_count SHALL combinationally show cnt[rd_sel] (0 when rd_sel>=NTIM); without it, rd_sel and rd_count SHALL be absent and no readback mux SHALL be built.

Verification
REQ-027 PRE=4, CW=8, cen=1, value0=8'hFE, start0=1: ovf[0] pulses 8 clk after the start write and every 8 clk thereafter; flags[0]=1 and irq_n=0 one clk later.
REQ-028 Timer 1 with value=8'hFF and start: ovf[1] period is 4*PRE cen pulses; timer 1 runs while timer 0 stays idle.
REQ-029 oneshot0=1, value0=8'hFD: exactly one ovf[0] pulse, then start0 reads 0 and cnt0 stays 8'hFD for 100 cycles.
REQ-030 clr_flags pulsed on the same edge as ovf[0] -> flags[0] stays 1; a later clr_flags alone -> flags[0]=0 and irq_n=1 one clk later.
REQ-031 mask0=1 while running -> ovf[0] still pulses, flags[0] stays 0; a mask write over a set flag clears it.
REQ-032 rst_n pulled low for 1 clk mid-count -> all outputs are at reset values immediately and no ovf occurs until restart.

Source files
------------

// File: rtl/jtopl_timer_bank.sv
// Bank of NTIM up-counting timers driven by a shared prescaled tick chain.
// Optional readback of the live counters is built when JTOPL_TIMER_RDBACK_EN is defined.
module jtopl_timer_bank #(
  parameter int NTIM = 2,
  parameter int CW   = 8,
  parameter int PRE  = 72
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_sel,
  input  logic [CW-1:0]   cfg_value,
  input  logic            ctl_we,
  input  logic [NTIM-1:0] ctl_start,
  input  logic [NTIM-1:0] ctl_mask,
  input  logic [NTIM-1:0] ctl_oneshot,
  input  logic            clr_flags,
`ifdef JTOPL_TIMER_RDBACK_EN
  input  logic [1:0]      rd_sel,
  output logic [CW-1:0]   rd_count,
`endif
  output logic [NTIM-1:0] flags,
  output logic [NTIM-1:0] ovf,
  output logic            irq_n
);

  localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);
  localparam int DW = (NTIM > 1) ? 2 * (NTIM - 1) : 1;

  logic [PW-1:0]   pre_reg;
  logic [DW-1:0]   div_reg;
  logic            tick0;
  logic [NTIM-1:0] tick;
  logic [CW-1:0]   cnt_reg   [NTIM];
  logic [CW-1:0]   value_reg [NTIM];
  logic [NTIM-1:0] start_reg, mask_reg, oneshot_reg;
  logic [NTIM-1:0] count_en, hit, start_rise, flag_set, flag_clr;

  assign tick0   = cen && (pre_reg == PRE_LAST);
  assign tick[0] = tick0;

  // One counter of tick0 events replaces the divide-by-4 cascade:
  // tick(i) fires when the low 2*i bits are all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_reg <= '0;
      div_reg <= '0;
    end else if (cen) begin
      pre_reg <= tick0 ? '0 : pre_reg + PW'(1);
      if (tick0) div_reg <= div_reg + DW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < NTIM; gi++) begin : g_tick
      assign tick[gi] = tick0 && (&div_reg[2*gi-1:0]);
    end

    for (gi = 0; gi < NTIM; gi++) begin : g_tim
      assign count_en[gi]   = start_reg[gi] && tick[gi];
      assign hit[gi]        = count_en[gi] && (cnt_reg[gi] == {CW{1'b1}});
      assign start_rise[gi] = ctl_we && ctl_start[gi] && !start_reg[gi];
      // A mask written on the overflow edge already suppresses that edge's flag
      assign flag_set[gi]   = hit[gi] && !(ctl_we ? ctl_mask[gi] : mask_reg[gi]);
      assign flag_clr[gi]   = clr_flags || (ctl_we && ctl_mask[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_reg   <= '0;
      mask_reg    <= '0;
      oneshot_reg <= '0;
      flags       <= '0;
      ovf         <= '0;
      irq_n       <= 1'b1;
      for (int i = 0; i < NTIM; i++) begin
        cnt_reg[i]   <= '0;
        value_reg[i] <= '0;
      end
    end else begin
      ovf   <= hit;
      irq_n <= ~|flags;
      if (ctl_we) begin
        mask_reg    <= ctl_mask;
        oneshot_reg <= ctl_oneshot;
      end
      for (int i = 0; i < NTIM; i++) begin
        if (cfg_we && cfg_sel == 2'(i)) value_reg[i] <= cfg_value;

        if (start_rise[i] || hit[i]) cnt_reg[i] <= value_reg[i];
        else if (count_en[i])        cnt_reg[i] <= cnt_reg[i] + CW'(1);

        // An explicit control write overrides the one-shot auto-stop
        if (ctl_we)                         start_reg[i] <= ctl_start[i];
        else if (hit[i] && oneshot_reg[i])  start_reg[i] <= 1'b0;

        if (flag_set[i])      flags[i] <= 1'b1;
        else if (flag_clr[i]) flags[i] <= 1'b0;
      end
    end
  end

`ifdef JTOPL_TIMER_RDBACK_EN
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NTIM; i++)
      if (rd_sel == 2'(i)) rd_count = cnt_reg[i];
  end
`endif

endmodule

// File: tb/tb_jtopl_timer_bank.sv
// Self-checking bench for jtopl_timer_bank: directed scenarios plus a randomized
// run, all compared cycle by cycle against an arithmetic reference model.
module tb_jtopl_timer_bank;

  localparam int NTIM = 2;
  localparam int CW   = 8;
  localparam int PRE  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cen;
  logic            cfg_we;
  logic [1:0]      cfg_sel;
  logic [CW-1:0]   cfg_value;
  logic            ctl_we;
  logic [NTIM-1:0] ctl_start, ctl_mask, ctl_oneshot;
  logic            clr_flags;
  logic [NTIM-1:0] flags, ovf;
  logic            irq_n;
`ifdef JTOPL_TIMER_RDBACK_EN
  logic [1:0]      rd_sel;
  logic [CW-1:0]   rd_count;
`endif

  jtopl_timer_bank #(.NTIM(NTIM), .CW(CW), .PRE(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_value(cfg_value),
    .ctl_we(ctl_we), .ctl_start(ctl_start), .ctl_mask(ctl_mask), .ctl_oneshot(ctl_oneshot),
    .clr_flags(clr_flags),
`ifdef JTOPL_TIMER_RDBACK_EN
    .rd_sel(rd_sel), .rd_count(rd_count),
`endif
    .flags(flags), .ovf(ovf), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tb_cyc   = 0;
  int q0[$];
  int q1[$];

  // Reference model: prescaler phase, total tick0 count, per-timer counters
  int              m_pre, m_t0;
  int              m_cnt [NTIM];
  int              m_val [NTIM];
  logic [NTIM-1:0] m_start, m_mask, m_os, m_flags, m_ovf;
  logic            m_irq_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, tb_cyc);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_t0 = 0;
    m_start = '0; m_mask = '0; m_os = '0; m_flags = '0; m_ovf = '0;
    m_irq_n = 1'b1;
    for (int i = 0; i < NTIM; i++) begin
      m_cnt[i] = 0;
      m_val[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic            t0, tk, en, ht;
    logic [NTIM-1:0] nflags, nstart;
    int              ncnt [NTIM];
    if (!rst_n) begin
      model_reset();
    end else begin
      t0 = cen && (m_pre == PRE - 1);
      for (int i = 0; i < NTIM; i++) begin
        tk = t0 && (((m_t0 + 1) % (1 << (2 * i))) == 0);
        en = m_start[i] && tk;
        ht = en && (m_cnt[i] == MAXC);
        ncnt[i] = m_cnt[i];
        if (ctl_we && ctl_start[i] && !m_start[i]) ncnt[i] = m_val[i];
        else if (ht)                               ncnt[i] = m_val[i];
        else if (en)                               ncnt[i] = m_cnt[i] + 1;
        nstart[i] = ctl_we ? ctl_start[i] : (m_start[i] && !(ht && m_os[i]));
        if (ht && !(ctl_we ? ctl_mask[i] : m_mask[i])) nflags[i] = 1'b1;
        else if (clr_flags || (ctl_we && ctl_mask[i])) nflags[i] = 1'b0;
        else                                           nflags[i] = m_flags[i];
        m_ovf[i] = ht;
      end
      m_irq_n = !(|m_flags);
      for (int i = 0; i < NTIM; i++) m_cnt[i] = ncnt[i];
      if (cfg_we && cfg_sel < NTIM) m_val[cfg_sel] = int'(cfg_value);
      m_start = nstart;
      m_flags = nflags;
      if (ctl_we) begin
        m_mask = ctl_mask;
        m_os   = ctl_oneshot;
      end
      if (cen) begin
        if (t0) m_t0++;
        m_pre = (m_pre + 1) % PRE;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    tb_cyc++;
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("flags", 32'(flags), 32'(m_flags));
    check("irq_n", 32'(irq_n), 32'(m_irq_n));
`ifdef JTOPL_TIMER_RDBACK_EN
    check("rd_count", 32'(rd_count), 32'(m_cnt[0]));
`endif
    if (ovf[0]) q0.push_back(tb_cyc);
    if (ovf[1]) q1.push_back(tb_cyc);
  endtask

  task automatic cfg_wr(input int sel, input logic [CW-1:0] v);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_value = v;
    $display("cyc %0d cfg_wr sel=%0d value=%h", tb_cyc + 1, sel, v);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic ctl_wr(input logic [NTIM-1:0] s, input logic [NTIM-1:0] m, input logic [NTIM-1:0] o);
    ctl_we = 1'b1; ctl_start = s; ctl_mask = m; ctl_oneshot = o;
    $display("cyc %0d ctl_wr start=%b mask=%b oneshot=%b", tb_cyc + 1, s, m, o);
    step();
    ctl_we = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    $display("cyc %0d clr_flags", tb_cyc + 1);
    step();
    clr_flags = 1'b0;
  endtask

  int   start_cyc, nxt, n0;
  logic fseen;

  initial begin
    rst_n = 1'b0; cen = 1'b1;
    cfg_we = 1'b0; cfg_sel = '0; cfg_value = '0;
    ctl_we = 1'b0; ctl_start = '0; ctl_mask = '0; ctl_oneshot = '0;
    clr_flags = 1'b0;
`ifdef JTOPL_TIMER_RDBACK_EN
    rd_sel = 2'd0;
`endif
    model_reset();
    step(); step();
    check("reset_flags", 32'(flags), 32'(0));
    check("reset_ovf", 32'(ovf), 32'(0));
    check("reset_irq_n", 32'(irq_n), 32'(1));
    rst_n = 1'b1;
    tb_cyc = 0;

    // Timer 0, reload FE, started on a tick-aligned edge: overflow every 8 clk
    cfg_wr(0, 8'hFE);
    step(); step();
    ctl_wr(2'b01, 2'b00, 2'b00);
    start_cyc = tb_cyc;
    q0.delete();
    repeat (26) step();
    check("ovf0_count", 32'(q0.size()), 32'(3));
    if (q0.size() >= 3) begin
      check("ovf0_first_delay", 32'(q0[0] - start_cyc), 32'(8));
      check("ovf0_period_a", 32'(q0[1] - q0[0]), 32'(8));
      check("ovf0_period_b", 32'(q0[2] - q0[1]), 32'(8));
    end
    check("flag0_set", 32'(flags[0]), 32'(1));
    check("irq_n_low", 32'(irq_n), 32'(0));

    // clr_flags alone, then coinciding with an overflow, then alone again
    nxt = (q0.size() > 0) ? q0[$] + 8 : tb_cyc + 8;
    pulse_clr();
    check("clr_alone_first", 32'(flags[0]), 32'(0));
    while (tb_cyc < nxt - 1) step();
    pulse_clr();
    check("clr_vs_ovf_pulse", 32'(ovf[0]), 32'(1));
    check("clr_vs_ovf_flag", 32'(flags[0]), 32'(1));
    step();
    pulse_clr();
    check("clr_alone_flag", 32'(flags[0]), 32'(0));
    step();
    check("clr_alone_irq_n", 32'(irq_n), 32'(1));

    // Mask write over a set flag clears it; masked overflows keep pulsing
    while (tb_cyc < nxt + 8) step();
    check("flag_before_mask", 32'(flags[0]), 32'(1));
    ctl_wr(2'b01, 2'b01, 2'b00);
    check("mask_write_clears", 32'(flags[0]), 32'(0));
    n0 = q0.size();
    fseen = 1'b0;
    repeat (20) begin
      step();
      fseen = fseen | flags[0];
    end
    check("masked_ovf_seen", 32'(q0.size() - n0 >= 2), 32'(1));
    check("masked_flag_quiet", 32'(fseen), 32'(0));

    // Timer 1 alone with reload FF: overflow every 4*PRE clk
    ctl_wr(2'b00, 2'b00, 2'b00);
    pulse_clr();
    cfg_wr(1, 8'hFF);
    ctl_wr(2'b10, 2'b00, 2'b00);
    q0.delete(); q1.delete();
    repeat (80) step();
    check("t0_idle", 32'(q0.size()), 32'(0));
    check("ovf1_count_min", 32'(q1.size() >= 4), 32'(1));
    if (q1.size() >= 3) begin
      check("ovf1_period_a", 32'(q1[1] - q1[0]), 32'(4 * PRE));
      check("ovf1_period_b", 32'(q1[2] - q1[1]), 32'(4 * PRE));
    end

    // One-shot: exactly one overflow, then silence
    ctl_wr(2'b00, 2'b00, 2'b00);
    pulse_clr();
    cfg_wr(0, 8'hFD);
    ctl_wr(2'b01, 2'b00, 2'b01);
    q0.delete(); q1.delete();
    repeat (120) step();
    check("oneshot_ovf_count", 32'(q0.size()), 32'(1));
`ifdef JTOPL_TIMER_RDBACK_EN
    check("oneshot_cnt_hold", 32'(rd_count), 32'(8'hFD));
`endif

    // Randomized traffic, including out-of-range cfg_sel and all-ones reloads
    ctl_wr(2'b00, 2'b00, 2'b00);
    for (int n = 0; n < 1500; n++) begin
      cen       = ($urandom_range(0, 9) != 0);
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_sel   = 2'($urandom_range(0, 3));
      cfg_value = CW'(8'hF0 | $urandom_range(0, 15));
      ctl_we    = ($urandom_range(0, 31) == 0);
      ctl_start = NTIM'($urandom);
      ctl_mask  = NTIM'($urandom);
      ctl_oneshot = NTIM'($urandom);
      clr_flags = ($urandom_range(0, 19) == 0);
      if (cfg_we || ctl_we || clr_flags)
        $display("cyc %0d rnd cen=%b cfg_we=%b sel=%0d val=%h ctl_we=%b st=%b mk=%b os=%b clr=%b",
                 tb_cyc + 1, cen, cfg_we, cfg_sel, cfg_value, ctl_we, ctl_start, ctl_mask,
                 ctl_oneshot, clr_flags);
      step();
    end
    cen = 1'b1; cfg_we = 1'b0; ctl_we = 1'b0; clr_flags = 1'b0;

    // Asynchronous reset mid-count
    cfg_wr(0, 8'hF0);
    cfg_wr(1, 8'hFF);
    ctl_wr(2'b11, 2'b00, 2'b00);
    repeat (20) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_flags", 32'(flags), 32'(0));
    check("async_rst_ovf", 32'(ovf), 32'(0));
    check("async_rst_irq_n", 32'(irq_n), 32'(1));
    step();
    rst_n = 1'b1;
    q0.delete(); q1.delete();
    repeat (80) step();
    check("no_ovf_after_rst", 32'(q0.size() + q1.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
